// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: checks alignment and range, drives a word-addressed
// data memory, merges sub-word stores through a read-modify-write and extends sub-word loads.
module mem_access_unit #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned CELDAS = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_MemRead,
  input  logic             i_MemWrite,
  input  logic [1:0]       i_Tamano,
  input  logic             i_Signed,
  input  logic [NBITS-1:0] i_Direccion,
  input  logic [NBITS-1:0] i_DatoStore,
  input  logic [NBITS-1:0] i_MemDato,
  output logic [NBITS-1:0] o_MemDireccion,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic [NBITS-1:0] o_MemDato,
  output logic [NBITS-1:0] o_DatoCarga,
  output logic             o_done,
  output logic             o_error,
  output logic             o_stall
);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d, data_q, data_d, carga_q, carga_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d, store_q, store_d;
  logic             rd_q, rd_d, wr_q, wr_d, done_q, done_d, err_q, err_d;

  logic             req, req_err;
  logic [NBITS-1:0] req_idx, lane_mask, merged, extended;
  logic [4:0]       shamt;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign req     = i_valid & (i_MemRead | i_MemWrite);
  assign req_idx = i_Direccion >> 2;

  always_comb begin
    req_err = 1'b0;
    case (i_Tamano)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = i_Direccion[0];
      2'b11:   req_err = |i_Direccion[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_idx >= NBITS'(CELDAS)) req_err = 1'b1;
    if (i_MemRead && i_MemWrite)   req_err = 1'b1;
  end

  // Little-endian lanes: byte k at bits [8k+7:8k], halfword h at [16h+15:16h].
  assign shamt     = {addr_q[1:0], 3'b000};
  assign ld_byte   = i_MemDato[shamt +: 8];
  assign ld_half   = i_MemDato[{addr_q[1], 4'b0000} +: 16];
  assign lane_mask = ((size_q == 2'b00) ? NBITS'(8'hFF) : NBITS'(16'hFFFF)) << shamt;
  assign merged    = (i_MemDato & ~lane_mask) | ((data_q << shamt) & lane_mask);

  always_comb begin
    case (size_q)
      2'b00:   extended = {{(NBITS-8){sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   extended = {{(NBITS-16){sgn_q & ld_half[15]}}, ld_half};
      default: extended = i_MemDato;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    carga_d = carga_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    store_d = store_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = i_Direccion;
          data_d  = i_DatoStore;
          size_d  = i_Tamano;
          sgn_d   = i_Signed;
          store_d = i_MemWrite;
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (i_MemWrite && i_Tamano == 2'b11) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (store_q) begin
          data_d  = merged;
          state_d = StWr;
        end else begin
          carga_d = extended;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StWr: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Strobes are registered so they follow the state they belong to exactly.
    rd_d = (state_d == StRd);
    wr_d = (state_d == StWr);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      carga_q <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      store_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      carga_q <= carga_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_MemDireccion = addr_q >> 2;
  assign o_MemRead      = rd_q;
  assign o_MemWrite     = wr_q;
  assign o_MemDato      = data_q;
  assign o_DatoCarga    = carga_q;
  assign o_done         = done_q;
  assign o_error        = err_q;
  assign o_stall        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a scoreboard of
// expected completions (latency, error flag, load result).
module tb_mem_access_unit;

  localparam int unsigned NBITS  = 32;
  localparam int unsigned CELDAS = 10;

  logic             clk = 1'b0;
  logic             rst, valid, mrd, mwr, sgn;
  logic [1:0]       tam;
  logic [NBITS-1:0] addr, sdata;
  logic [NBITS-1:0] mem_rdata = '0;
  logic [NBITS-1:0] o_MemDireccion, o_MemDato, o_DatoCarga;
  logic             o_MemRead, o_MemWrite, o_done, o_error, o_stall;

  mem_access_unit #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .i_MemRead      (mrd),
    .i_MemWrite     (mwr),
    .i_Tamano       (tam),
    .i_Signed       (sgn),
    .i_Direccion    (addr),
    .i_DatoStore    (sdata),
    .i_MemDato      (mem_rdata),
    .o_MemDireccion (o_MemDireccion),
    .o_MemRead      (o_MemRead),
    .o_MemWrite     (o_MemWrite),
    .o_MemDato      (o_MemDato),
    .o_DatoCarga    (o_DatoCarga),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_stall        (o_stall)
  );

  always #5 clk = ~clk;

  // Data memory: read sampled at posedge, data valid next cycle; write on negedge.
  logic [NBITS-1:0] mem [CELDAS];
  logic             mem_clr;
  int               wr_cnt = 0;
  int               rd_cnt = 0;
  logic             both_seen = 1'b0;

  always @(posedge clk) begin
    if (o_MemRead)
      mem_rdata <= (o_MemDireccion < CELDAS) ? mem[o_MemDireccion[3:0]] : 32'hDEAD_BEEF;
    if (o_MemWrite) wr_cnt <= wr_cnt + 1;
    if (o_MemRead) rd_cnt <= rd_cnt + 1;
    if (o_MemRead && o_MemWrite) both_seen <= 1'b1;
  end

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < CELDAS; i++) mem[i] <= '0;
    end else if (o_MemWrite && o_MemDireccion < CELDAS) begin
      mem[o_MemDireccion[3:0]] <= o_MemDato;
    end
  end

  typedef struct {
    int unsigned lat;
    logic        err;
    logic [31:0] carga;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_carga = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] t, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; mrd = rd; mwr = wr; tam = t; sgn = s; addr = a; sdata = d;
    @(posedge clk); #1;
    valid = 1'b0; mrd = 1'b0; mwr = 1'b0;
  endtask

  // Waits for o_done (bounded), pops the scoreboard and compares.
  task automatic wait_done(input string tag);
    exp_t        e;
    int unsigned k;
    logic        stall_ok;
    e = sb.pop_front();
    k = 1;
    stall_ok = 1'b1;
    while (o_done !== 1'b1 && k < 10) begin
      if (o_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".done"}, {31'b0, o_done}, 32'd1);
    check({tag, ".latency"}, k, e.lat);
    check({tag, ".error"}, {31'b0, o_error}, {31'b0, e.err});
    check({tag, ".carga"}, o_DatoCarga, e.carga);
    check({tag, ".stall"}, {31'b0, stall_ok & ~o_stall}, 32'd1);
  endtask

  task automatic req(input string tag, input logic rd, input logic wr, input logic [1:0] t,
                     input logic s, input logic [31:0] a, input logic [31:0] d,
                     input int unsigned lat, input logic err, input logic [31:0] carga);
    exp_t e;
    if (rd && !err) last_carga = carga;
    e.lat = lat; e.err = err; e.carga = err ? last_carga : (rd ? carga : last_carga);
    sb.push_back(e);
    issue(rd, wr, t, s, a, d);
    wait_done(tag);
  endtask

  int          snap_wr, snap_rd, dones;
  logic [31:0] snap_mem;

  initial begin
    rst = 1'b1; mem_clr = 1'b1; valid = 1'b0; mrd = 1'b0; mwr = 1'b0;
    tam = 2'b00; sgn = 1'b0; addr = '0; sdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    check("reset.outputs", {31'b0, |{o_MemDireccion, o_MemRead, o_MemWrite, o_MemDato,
                                     o_DatoCarga, o_done, o_error, o_stall}}, 32'd0);

    // Preload through the unit with word stores.
    req("st_w2", 0, 1, 2'b11, 0, 32'h8, 32'h8081_7F80, 2, 0, 0);
    check("mem.w2", mem[2], 32'h8081_7F80);
    req("st_w1", 0, 1, 2'b11, 0, 32'h4, 32'h0000_000F, 2, 0, 0);
    check("mem.w1", mem[1], 32'h0000_000F);

    req("ldb_9s",  1, 0, 2'b00, 1, 32'h9, 0, 3, 0, 32'h0000_007F);
    req("ldb_bs",  1, 0, 2'b00, 1, 32'hB, 0, 3, 0, 32'hFFFF_FF80);
    req("ldb_bu",  1, 0, 2'b00, 0, 32'hB, 0, 3, 0, 32'h0000_0080);
    req("ldh_as",  1, 0, 2'b01, 1, 32'hA, 0, 3, 0, 32'hFFFF_8081);
    req("ldh_au",  1, 0, 2'b01, 0, 32'hA, 0, 3, 0, 32'h0000_8081);
    req("ldw_8",   1, 0, 2'b11, 1, 32'h8, 0, 3, 0, 32'h8081_7F80);

    // Byte store followed back-to-back by a load issued on its done cycle.
    snap_wr = wr_cnt;
    req("stb_5",   0, 1, 2'b00, 0, 32'h5, 32'h0000_00AA, 4, 0, 0);
    req("ldw_4",   1, 0, 2'b11, 0, 32'h4, 0, 3, 0, 32'h0000_AA0F);
    check("stb_5.writes", wr_cnt - snap_wr, 1);
    check("mem.w1_merged", mem[1], 32'h0000_AA0F);

    req("sth_a",   0, 1, 2'b01, 0, 32'hA, 32'h1234_BEEF, 4, 0, 0);
    check("mem.w2_merged", mem[2], 32'hBEEF_7F80);
    req("ldh_a2",  1, 0, 2'b01, 0, 32'hA, 0, 3, 0, 32'h0000_BEEF);

    // Last valid word index, then rejected requests.
    req("st_w9",   0, 1, 2'b11, 0, 32'h24, 32'hCAFE_F00D, 2, 0, 0);
    req("ld_w9",   1, 0, 2'b11, 0, 32'h24, 0, 3, 0, 32'hCAFE_F00D);
    snap_wr = wr_cnt; snap_rd = rd_cnt; snap_mem = mem[1];
    req("err_mis", 0, 1, 2'b11, 0, 32'h6,  32'h1234_5678, 1, 1, 0);
    req("err_rng", 0, 1, 2'b11, 0, 32'h28, 32'h1234_5678, 1, 1, 0);
    req("err_rsv", 1, 0, 2'b10, 0, 32'h8,  0, 1, 1, 0);
    req("err_hm",  1, 0, 2'b01, 0, 32'h9,  0, 1, 1, 0);
    req("err_rw",  1, 1, 2'b00, 0, 32'h4,  32'h55, 1, 1, 0);
    check("err.no_writes", wr_cnt - snap_wr, 0);
    check("err.no_reads", rd_cnt - snap_rd, 0);
    check("err.mem_w1", mem[1], snap_mem);

    // Request with neither read nor write is ignored.
    issue(0, 0, 2'b11, 0, 32'h4, 32'h0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_done || o_stall) dones++;
      @(posedge clk); #1;
    end
    check("idle_req.ignored", dones, 0);
    check("idle_req.carga", o_DatoCarga, last_carga);

    // Reset during CAP of a byte store aborts it without any write.
    snap_wr = wr_cnt; snap_mem = mem[1];
    issue(0, 1, 2'b00, 0, 32'h4, 32'h0000_0055);
    @(posedge clk); #1;
    check("rst.in_cap_stall", {31'b0, o_stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst.outputs", {31'b0, |{o_MemDireccion, o_MemRead, o_MemWrite, o_MemDato,
                                   o_DatoCarga, o_done, o_error, o_stall}}, 32'd0);
    rst = 1'b0;
    last_carga = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.no_write", wr_cnt - snap_wr, 0);
    check("rst.mem_w1", mem[1], snap_mem);
    req("ld_after_rst", 1, 0, 2'b11, 0, 32'h8, 0, 3, 0, 32'hBEEF_7F80);

    check("strobes.exclusive", {31'b0, both_seen}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-addressed data memory.
- Takes byte addresses and size/sign qualifiers from the EX/MEM latch, checks alignment and range, and drives the memory's word address, read/write strobes and write data.
- Performs read-modify-write for byte/halfword stores. Extracts and sign/zero-extends byte/halfword loads.
- Stalls the pipeline while a multi-cycle access is in flight.

Parameters:
- NBITS, 32, datapath and address width.
- CELDAS, 10, number of words in the data memory; word index must be < CELDAS.

Ports:
- i_clk  in  1  clock. One clock domain; synchronous, active-high reset.
- i_reset  in  1  synchronous active-high reset.
- i_valid  in  1  request present; sampled only in IDLE.
- i_MemRead  in  1  load request.
- i_MemWrite  in  1  store request.
- i_Tamano  in  2  access size: 00 byte, 01 halfword, 11 word, 10 reserved.
- i_Signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- i_Direccion  in  NBITS  byte address.
- i_DatoStore  in  NBITS  store data, right-aligned.
- i_MemDato  in  NBITS  data memory read data; valid one cycle after o_MemRead.
- o_MemDireccion  out  NBITS  word index = latched address >> 2.
- o_MemRead  out  1  memory read strobe; memory samples it at posedge.
- o_MemWrite  out  1  memory write strobe; memory writes on negedge of the same cycle.
- o_MemDato  out  NBITS  write data (merged for sub-word stores).
- o_DatoCarga  out  NBITS  extended load result.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  qualifies o_done: request rejected.
- o_stall  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including o_DatoCarga, strobes, o_done and o_error.
  - Reset mid-operation aborts the access. No strobe is asserted in any cycle after reset is sampled, so no write occurs.
- States: IDLE, RD, CAP, WR.
- Request latching: with i_valid sampled high at the end of IDLE cycle T, the unit latches address, size, sign and data.
- Error path (no memory access; next cycle T+1 is IDLE with o_done=1, o_error=1). Any of the following rejects the request:
  - i_Tamano = 10;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >> 2 >= CELDAS;
  - i_MemRead and i_MemWrite both high.
- Idle request: i_valid with neither i_MemRead nor i_MemWrite is ignored. No done pulse, state stays IDLE.
- Load: IDLE -> RD (T+1, o_MemRead = 1) -> CAP (T+2, i_MemDato valid, result registered at end of cycle) -> IDLE.
  - o_done and the new o_DatoCarga appear at T+3.
- Word store: IDLE -> WR (T+1, o_MemWrite = 1, o_MemDato = latched data) -> IDLE.
  - o_done at T+2.
- Sub-word store: IDLE -> RD (T+1) -> CAP (T+2, merge registered) -> WR (T+3) -> IDLE.
  - o_done at T+4.
- Lane mapping (little-endian): byte lane k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane h = addr[1] occupies bits [16h+15:16h].
- Merge: replace only the addressed lane with the low 8/16 bits of the store data. All other bits come from the read word.
- Load extension: the selected lane is right-aligned. Upper bits are filled with the lane MSB if i_Signed, else 0. A word load passes through unchanged.
- Strobe timing:
  - o_MemDireccion is stable from RD/WR entry through the end of the access.
  - o_MemRead is high only in RD; o_MemWrite is high only in WR. They are never high together.
- Output holding:
  - o_DatoCarga holds its value until the next successful load; stores and errors do not change it.
  - o_done and o_error are single-cycle pulses.
- Stall: o_stall = (state != IDLE), combinational. A new request can be accepted in the same cycle o_done is high.
- Address arithmetic: no wrap-around; an out-of-range index is an error, never aliased.

Test Plan:
- Preload word2 = 0x80817F80. Byte load, addr 0x9, signed -> o_DatoCarga = 0x0000007F at T+3. Addr 0xB signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Preload word2 = 0x80817F80. Halfword load, addr 0xA, signed -> 0xFFFF8081; unsigned -> 0x00008081. o_stall high T+1..T+2.
- Preload word1 = 0x0000000F. Byte store 0x000000AA to addr 0x5 -> word1 = 0x0000AA0F, o_done at T+4, o_stall high T+1..T+3, exactly one o_MemWrite cycle.
- Word store 0x12345678 to addr 0x6 -> o_done = o_error = 1 at T+1, no strobes. Repeat with addr 0x28 (CELDAS = 10) -> same error.
- Assert i_reset during CAP of a byte store -> no o_MemWrite ever, memory unchanged, all outputs 0 next cycle. A fresh word load afterwards completes at T+3.
- Back-to-back: load issued on the o_done cycle of a previous store -> accepted, no idle bubble, both results correct.
